// File: rtl/pipe_stage_buf_if.sv
// Stage-boundary handshake bundle: upstream valid/ready/payload, flush, downstream
// valid/ready/payload, plus occupancy and stall-count observability.
interface pipe_stage_buf_if #(
  parameter int PAYLOAD_W = 135,
  parameter int CNT_W     = 16
);
  logic                 valid_i;
  logic                 ready_o;
  logic [PAYLOAD_W-1:0] payload_i;
  logic                 RegWrite_i;
  logic                 flush_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [PAYLOAD_W-1:0] payload_o;
  logic                 RegWrite_o;
  logic [1:0]           occupancy_o;
  logic [CNT_W-1:0]     stall_cnt_o;

  modport slave (
    input  valid_i, payload_i, RegWrite_i, flush_i, ready_i,
    output ready_o, valid_o, payload_o, RegWrite_o, occupancy_o, stall_cnt_o
  );

  modport master (
    output valid_i, payload_i, RegWrite_i, flush_i, ready_i,
    input  ready_o, valid_o, payload_o, RegWrite_o, occupancy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with a two-entry skid buffer: ready_o depends only on
// registered state, so downstream stalls never reach upstream combinationally.
module pipe_stage_buf #(
  parameter int PAYLOAD_W = 135,
  parameter int CNT_W     = 16
) (
  input logic                clk_i,
  input logic                reset_i,
  pipe_stage_buf_if.slave    bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q;
  logic [PAYLOAD_W-1:0] head_p0;
  logic                 head_rw_p0;
  logic [PAYLOAD_W-1:0] skid_p1;
  logic                 skid_rw_p1;
  logic [CNT_W-1:0]     stall_cnt_q;

  logic in_xfer;
  logic out_xfer;
  logic stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign bus.ready_o     = (state_q != FULL);
  assign bus.valid_o     = (state_q != EMPTY);
  assign bus.payload_o   = head_p0;
  assign bus.RegWrite_o  = head_rw_p0 & bus.valid_o;
  assign bus.occupancy_o = state_q;
  assign bus.stall_cnt_o = stall_cnt_q;

  assign in_xfer  = bus.valid_i & bus.ready_o;
  assign out_xfer = bus.valid_o & bus.ready_i;
  assign stall    = bus.valid_o & ~bus.ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      head_p0     <= '0;
      head_rw_p0  <= 1'b0;
      skid_p1     <= '0;
      skid_rw_p1  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (bus.flush_i) begin
        // Held and incoming entries are dropped; payload keeps its last value.
        state_q <= EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              head_p0    <= bus.payload_i;
              head_rw_p0 <= bus.RegWrite_i;
              state_q    <= ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              head_p0    <= bus.payload_i;
              head_rw_p0 <= bus.RegWrite_i;
            end else if (in_xfer) begin
              // Head is stalled: park the new entry behind it.
              skid_p1    <= bus.payload_i;
              skid_rw_p1 <= bus.RegWrite_i;
              state_q    <= FULL;
            end else if (out_xfer) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              head_p0    <= skid_p1;
              head_rw_p0 <= skid_rw_p1;
              state_q    <= ONE;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a queue scoreboard tracks held entries and
// the stall counter; a second narrow-counter instance checks saturation.
module tb_pipe_stage_buf;
  localparam int PW = 135;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  pipe_stage_buf_if #(.PAYLOAD_W(PW), .CNT_W(16)) a ();
  pipe_stage_buf_if #(.PAYLOAD_W(PW), .CNT_W(3))  b ();

  pipe_stage_buf #(.PAYLOAD_W(PW), .CNT_W(16)) dut_a (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (a.slave)
  );

  pipe_stage_buf #(.PAYLOAD_W(PW), .CNT_W(3)) dut_b (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (b.slave)
  );

  typedef struct {
    logic [PW-1:0] p;
    logic          rw;
  } entry_t;

  entry_t q[$];
  int     checks = 0;
  int     errors = 0;
  int     exp_cnt = 0;
  int     nxt;
  bit     acc;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check DUT a against the model, then advance one clock with the current inputs.
  task automatic cycle(output bit accepted);
    entry_t e;
    bit     do_in, do_out;
    int     sz;
    sz = q.size();
    chk("valid_o", a.valid_o, sz != 0);
    chk("ready_o", a.ready_o, sz < 2);
    chk("occupancy_o", a.occupancy_o, sz);
    chk("stall_cnt_o", a.stall_cnt_o, exp_cnt);
    if (sz == 0) chk("RegWrite_squash", a.RegWrite_o, 1'b0);
    do_out = (sz != 0) && a.ready_i;
    do_in  = a.valid_i && (sz < 2);
    if (do_out) begin
      e = q.pop_front();
      chk("payload_o", a.payload_o, e.p);
      chk("RegWrite_o", a.RegWrite_o, e.rw);
    end
    if (sz != 0 && !a.ready_i && exp_cnt < 65535) exp_cnt++;
    accepted = do_in && !a.flush_i;
    if (a.flush_i) q.delete();
    else if (do_in) q.push_back('{p: a.payload_i, rw: a.RegWrite_i});
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int p, input bit rw, input bit rdy, input bit fl);
    a.valid_i    = v;
    a.payload_i  = PW'(p);
    a.RegWrite_i = rw;
    a.ready_i    = rdy;
    a.flush_i    = fl;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid_o"}, a.valid_o, 1'b0);
    chk({tag, "_ready_o"}, a.ready_o, 1'b1);
    chk({tag, "_RegWrite_o"}, a.RegWrite_o, 1'b0);
    chk({tag, "_payload_o"}, a.payload_o, '0);
    chk({tag, "_occupancy_o"}, a.occupancy_o, 2'd0);
    chk({tag, "_stall_cnt_o"}, a.stall_cnt_o, '0);
  endtask

  task automatic do_reset(input bit with_flush);
    reset_i   = 1'b1;
    a.flush_i = with_flush;
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    a.flush_i = 1'b0;
    q.delete();
    exp_cnt = 0;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(0, 0, 0, 1, 0);
    b.valid_i = 1'b0; b.payload_i = '0; b.RegWrite_i = 1'b0;
    b.flush_i = 1'b0; b.ready_i = 1'b0;
    do_reset(0);
    check_reset_vals("reset");
    chk("b_stall_cnt_reset", b.stall_cnt_o, 3'd0);

    // Stream 1..8 with ready_i held high, RegWrite alternating 1/0.
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, i[0], 1, 0);
      cycle(acc);
      chk("stream_accept", acc, 1'b1);
    end
    drive(0, 0, 0, 1, 0);
    cycle(acc);
    chk("stream_stall_cnt", a.stall_cnt_o, 0);

    // Stall downstream for 3 cycles while upstream keeps offering.
    nxt = 9;
    for (int k = 0; k < 12; k++) begin
      drive(1, nxt, nxt[0], !(k >= 3 && k <= 5), 0);
      cycle(acc);
      if (acc) nxt++;
    end
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cycle(acc);
    chk("stall3_cnt", a.stall_cnt_o, 16'd3);

    // Fill to FULL with A/B, then flush with C offered.
    drive(1, 'hA, 1, 0, 0); cycle(acc);
    drive(1, 'hB, 1, 0, 0); cycle(acc);
    chk("full_occ", a.occupancy_o, 2'd2);
    drive(1, 'hC, 1, 0, 1); cycle(acc);
    drive(0, 0, 0, 1, 0);
    chk("flush_valid_o", a.valid_o, 1'b0);
    chk("flush_RegWrite_o", a.RegWrite_o, 1'b0);
    chk("flush_occ", a.occupancy_o, 2'd0);
    chk("flush_keeps_cnt", a.stall_cnt_o, 16'd5);
    for (int k = 0; k < 3; k++) cycle(acc);

    // Reach FULL with stall count 5, then reset.
    do_reset(0);
    drive(1, 'hD, 1, 0, 0); cycle(acc);
    drive(1, 'hE, 0, 0, 0); cycle(acc);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 20 && exp_cnt < 5; k++) cycle(acc);
    chk("pre_reset_occ", a.occupancy_o, 2'd2);
    chk("pre_reset_cnt", a.stall_cnt_o, 16'd5);
    do_reset(0);
    check_reset_vals("reset_full");
    drive(0, 0, 0, 1, 0);
    cycle(acc);

    // Narrow counter saturates at 7 and holds.
    b.valid_i = 1'b1; b.payload_i = PW'(1); b.ready_i = 1'b0;
    @(posedge clk_i); #1;
    b.valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin @(posedge clk_i); #1; end
    chk("b_cnt5", b.stall_cnt_o, 3'd5);
    for (int k = 0; k < 5; k++) begin @(posedge clk_i); #1; end
    chk("b_cnt_sat", b.stall_cnt_o, 3'd7);
    @(posedge clk_i); #1;
    chk("b_cnt_hold", b.stall_cnt_o, 3'd7);
    chk("b_valid_o", b.valid_o, 1'b1);

    // Reset and flush together while holding an entry with a nonzero count.
    drive(1, 'h55, 1, 0, 0); cycle(acc);
    drive(0, 0, 0, 0, 0);
    cycle(acc);
    cycle(acc);
    drive(1, 'h66, 1, 0, 0);
    do_reset(1);
    check_reset_vals("reset_flush");
    chk("b_reset_cnt", b.stall_cnt_o, 3'd0);
    drive(0, 0, 0, 1, 0);
    cycle(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
